fc_param_store: RTL and testbench
=================================

// Module: fc_param_store
// PURPOSE
//   Responder side of the FullyConnected weight/bias read interfaces. Holds one layer's
//   weights (packed BURST_LEN per word) and biases, and serves w_/b_read requests with one
//   cycle of latency. Parameters are loaded beforehand from a byte stream (valid/ready/last)
//   driven by the host loader; one instance sits beside each fully-connected layer.
// PARAMETERS
//   INPUT_SIZE    512  inputs per neuron (multiple of BURST_LEN)
//   OUTPUT_SIZE   256  neurons; bias entries
//   WEIGHTS_WIDTH 8    weight width; also load-stream beat width
//   BURST_LEN     4    weights per read word
//   BIAS_WIDTH    32   bias width (multiple of WEIGHTS_WIDTH)
// PORTS
//   clk         in   1                               clock, all logic on rising edge
//   rst_n       in   1                               synchronous reset, active low
//   load_start  in   1                               pulse: begin (re)load of all parameters
//   s_valid     in   1                               load beat valid
//   s_ready     out  1                               load beat accepted when s_valid&&s_ready
//   s_data      in   WEIGHTS_WIDTH                   load beat payload
//   s_last      in   1                               marks final beat of the load
//   loaded      out  1                               full parameter set resident and valid
//   load_err    out  1                               sticky: last-beat mismatch; cleared by load_start
//   w_read_en   in   1                               weight read request
//   w_read_addr in   $clog2(INPUT_SIZE*OUTPUT_SIZE)  element index (node*INPUT_SIZE+i)
//   w_read_data out  BURST_LEN*WEIGHTS_WIDTH         packed weights, signed
//   b_read_en   in   1                               bias read request
//   b_read_addr in   $clog2(OUTPUT_SIZE)             neuron index
//   b_read_data out  BIAS_WIDTH                      bias, signed
// BEHAVIOUR
//   Reset: state IDLE, loaded=0, load_err=0, w_read_data=0, b_read_data=0, counters=0;
//     memory arrays are not cleared. Reset mid-load aborts it; loaded stays 0.
//   FSM IDLE -> LOAD_W -> LOAD_B -> READY. load_start in any state: -> LOAD_W, byte/word/
//     bias counters and pack register cleared, loaded<=0, load_err<=0.
//   s_ready = (state==LOAD_W || state==LOAD_B) && !load_start (combinational); a beat
//     presented in the same cycle as load_start is not accepted.
//   LOAD_W: beats shift into pack reg, first beat of a group lands in MSBs
//     (element k at bits [(BURST_LEN-k)*W-1 -: W]); on the BURST_LEN-th beat the word is
//     written to word index (beat_count/BURST_LEN). After INPUT_SIZE*OUTPUT_SIZE beats -> LOAD_B.
//   LOAD_B: BIAS_WIDTH/WEIGHTS_WIDTH beats per bias, MSB byte first; bias j written on its
//     last byte. After OUTPUT_SIZE biases -> READY, loaded<=1 next edge.
//   s_last must coincide with the final bias byte. s_last on any earlier beat, or the final
//     byte without s_last: beat discarded, load_err<=1, loaded stays 0, -> IDLE.
//   Beats while s_ready=0 are ignored; s_valid gaps are legal at any point.
//   Reads: served in every state. On an edge with w_read_en=1, w_read_data <=
//     word[w_read_addr/BURST_LEN] (low log2(BURST_LEN) addr bits ignored); w_read_en=0
//     holds w_read_data. Bias identical: b_read_data <= bias[b_read_addr] when b_read_en.
//     Latency: addr at edge N -> data valid after edge N+1 (matches FC PENDING/STORE timing).
//     Reads and a load write to the same word in one cycle return the old contents.
//   Out-of-range b_read_addr (>=OUTPUT_SIZE) returns 0. Both read ports are independent
//     and may be active in the same cycle.
// TESTING (INPUT_SIZE=8, OUTPUT_SIZE=2, BURST_LEN=4, BIAS_WIDTH=32)
//   Load bytes 0x01..0x10 then 00 00 00 64, FF FF FF 9C with s_last on last -> loaded=1;
//     w_read_addr=0 -> 0x01020304, addr=12 -> 0x0D0E0F10, b_read_addr=1 -> -100, 1 cycle later.
//   Same load with random s_valid gaps -> identical contents; w_read_addr=5 -> 0x05060708.
//   s_last on beat 10 -> load_err=1, loaded=0, state IDLE; next load_start clears load_err.
//   rst_n=0 after 6 beats -> loaded=0, read data 0; fresh full load then succeeds.
//   load_start asserted with s_valid=1 in LOAD_W -> that beat not accepted, counters at 0.
//   w_read_en=1 at addr 4 then 0 for 3 cycles -> w_read_data holds 0x05060708.

Source files
------------

// File: rtl/fc_param_store.sv
// fc_param_store: weight/bias parameter memory for one fully-connected layer.
// Parameters arrive as a byte stream (weights first, then biases, MSB byte first).
// Reads have one registered cycle of latency and are served in every state.
module fc_param_store #(
  parameter int INPUT_SIZE    = 512,
  parameter int OUTPUT_SIZE   = 256,
  parameter int WEIGHTS_WIDTH = 8,
  parameter int BURST_LEN     = 4,
  parameter int BIAS_WIDTH    = 32
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       load_start,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  input  logic [WEIGHTS_WIDTH-1:0]                   s_data,
  input  logic                                       s_last,
  output logic                                       loaded,
  output logic                                       load_err,
  input  logic                                       w_read_en,
  input  logic [$clog2(INPUT_SIZE*OUTPUT_SIZE)-1:0]  w_read_addr,
  output logic [BURST_LEN*WEIGHTS_WIDTH-1:0]         w_read_data,
  input  logic                                       b_read_en,
  input  logic [$clog2(OUTPUT_SIZE)-1:0]             b_read_addr,
  output logic [BIAS_WIDTH-1:0]                      b_read_data
);

  localparam int W_AW    = $clog2(INPUT_SIZE*OUTPUT_SIZE);
  localparam int B_AW    = $clog2(OUTPUT_SIZE);
  localparam int BL_LOG2 = $clog2(BURST_LEN);
  localparam int N_WORDS = INPUT_SIZE*OUTPUT_SIZE/BURST_LEN;
  localparam int WORD_W  = BURST_LEN*WEIGHTS_WIDTH;
  localparam int BPB     = BIAS_WIDTH/WEIGHTS_WIDTH;
  localparam int BC_W    = (BPB > 1) ? $clog2(BPB) : 1;

  localparam logic [W_AW-1:0] W_LAST    = W_AW'(INPUT_SIZE*OUTPUT_SIZE-1);
  localparam logic [W_AW-1:0] GRP_MASK  = W_AW'(BURST_LEN-1);
  localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(BPB-1);
  localparam logic [B_AW-1:0] BIAS_LAST = B_AW'(OUTPUT_SIZE-1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_READY  = 2'd3
  } state_e;

  // Parameter storage (intentionally not cleared by reset)
  logic [WORD_W-1:0]     w_mem [N_WORDS];
  logic [BIAS_WIDTH-1:0] b_mem [OUTPUT_SIZE];

  state_e                          state_q, state_d;
  logic [W_AW-1:0]                 w_cnt_q, w_cnt_d;
  logic [BC_W-1:0]                 byte_cnt_q, byte_cnt_d;
  logic [B_AW-1:0]                 bias_cnt_q, bias_cnt_d;
  // Pack registers hold only the bytes already received for the current group;
  // the incoming byte completes the word directly.
  logic [WORD_W-WEIGHTS_WIDTH-1:0] w_pack_q, w_pack_d;
  logic [BIAS_WIDTH-WEIGHTS_WIDTH-1:0] b_pack_q, b_pack_d;
  logic                            loaded_q, loaded_d;
  logic                            load_err_q, load_err_d;
  logic [WORD_W-1:0]               w_rdata_q, w_rdata_d;
  logic [BIAS_WIDTH-1:0]           b_rdata_q, b_rdata_d;

  logic                            s_ready_s;
  logic                            accept_s;
  logic                            final_s;
  logic                            w_we_s;
  logic                            b_we_s;
  logic [WORD_W-1:0]               w_word_s;
  logic [BIAS_WIDTH-1:0]           b_word_s;
  logic                            b_in_range_s;
  logic                            unused_addr_s;

  assign s_ready_s = ((state_q == ST_LOAD_W) || (state_q == ST_LOAD_B)) && !load_start;
  assign accept_s  = s_valid && s_ready_s;
  assign final_s   = (byte_cnt_q == BYTE_LAST) && (bias_cnt_q == BIAS_LAST);
  assign w_word_s  = {w_pack_q, s_data};
  assign b_word_s  = {b_pack_q, s_data};
  // Low address bits select an element inside a word; the port returns whole words.
  assign unused_addr_s = ^w_read_addr[BL_LOG2-1:0];

  generate
    if (OUTPUT_SIZE < (1 << B_AW)) begin : g_b_partial
      localparam logic [B_AW-1:0] B_END = B_AW'(OUTPUT_SIZE);
      assign b_in_range_s = (b_read_addr < B_END);
    end else begin : g_b_full
      assign b_in_range_s = 1'b1;
    end
  endgenerate

  // Load FSM: next state, counters, pack registers, status flags and memory write strobes
  always_comb begin
    state_d    = state_q;
    w_cnt_d    = w_cnt_q;
    byte_cnt_d = byte_cnt_q;
    bias_cnt_d = bias_cnt_q;
    w_pack_d   = w_pack_q;
    b_pack_d   = b_pack_q;
    loaded_d   = loaded_q;
    load_err_d = load_err_q;
    w_we_s     = 1'b0;
    b_we_s     = 1'b0;
    if (load_start) begin
      state_d    = ST_LOAD_W;
      w_cnt_d    = '0;
      byte_cnt_d = '0;
      bias_cnt_d = '0;
      w_pack_d   = '0;
      b_pack_d   = '0;
      loaded_d   = 1'b0;
      load_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD_W: begin
          if (!accept_s) begin
            w_we_s = 1'b0;
          end else if (s_last) begin
            // Stream ended early: drop the beat and abort
            state_d    = ST_IDLE;
            load_err_d = 1'b1;
            loaded_d   = 1'b0;
          end else begin
            w_pack_d = w_word_s[WORD_W-WEIGHTS_WIDTH-1:0];
            w_we_s   = ((w_cnt_q & GRP_MASK) == GRP_MASK);
            if (w_cnt_q == W_LAST) begin
              state_d = ST_LOAD_B;
              w_cnt_d = '0;
            end else begin
              w_cnt_d = w_cnt_q + 1'b1;
            end
          end
        end
        ST_LOAD_B: begin
          if (!accept_s) begin
            b_we_s = 1'b0;
          end else if (final_s != s_last) begin
            // s_last must mark exactly the final bias byte
            state_d    = ST_IDLE;
            load_err_d = 1'b1;
            loaded_d   = 1'b0;
          end else begin
            b_pack_d = b_word_s[BIAS_WIDTH-WEIGHTS_WIDTH-1:0];
            if (byte_cnt_q == BYTE_LAST) begin
              b_we_s     = 1'b1;
              byte_cnt_d = '0;
              if (final_s) begin
                state_d    = ST_READY;
                loaded_d   = 1'b1;
                bias_cnt_d = '0;
              end else begin
                bias_cnt_d = bias_cnt_q + 1'b1;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
        ST_IDLE:  state_d = ST_IDLE;
        ST_READY: state_d = ST_READY;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Read ports: capture addressed word/bias when enabled, otherwise hold
  always_comb begin
    w_rdata_d = w_rdata_q;
    b_rdata_d = b_rdata_q;
    if (w_read_en) begin
      w_rdata_d = w_mem[w_read_addr[W_AW-1:BL_LOG2]];
    end else begin
      w_rdata_d = w_rdata_q;
    end
    if (!b_read_en) begin
      b_rdata_d = b_rdata_q;
    end else if (b_in_range_s) begin
      b_rdata_d = b_mem[b_read_addr];
    end else begin
      b_rdata_d = '0;
    end
  end

  // Control and read-data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      w_cnt_q    <= '0;
      byte_cnt_q <= '0;
      bias_cnt_q <= '0;
      w_pack_q   <= '0;
      b_pack_q   <= '0;
      loaded_q   <= 1'b0;
      load_err_q <= 1'b0;
      w_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      w_cnt_q    <= w_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      bias_cnt_q <= bias_cnt_d;
      w_pack_q   <= w_pack_d;
      b_pack_q   <= b_pack_d;
      loaded_q   <= loaded_d;
      load_err_q <= load_err_d;
      w_rdata_q  <= w_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Memory writes; suppressed during reset so an aborted load cannot write
  always_ff @(posedge clk) begin
    if (rst_n && w_we_s) begin
      w_mem[w_cnt_q[W_AW-1:BL_LOG2]] <= w_word_s;
    end
    if (rst_n && b_we_s) begin
      b_mem[bias_cnt_q] <= b_word_s;
    end
  end

  assign s_ready     = s_ready_s;
  assign loaded      = loaded_q;
  assign load_err    = load_err_q;
  assign w_read_data = w_rdata_q;
  assign b_read_data = b_rdata_q;

endmodule

// File: tb/tb_fc_param_store.sv
// Self-checking bench for fc_param_store (INPUT_SIZE=8, OUTPUT_SIZE=2).
// Reference model: byte stream array; words/biases committed from complete groups.
module tb_fc_param_store;

  localparam int IS = 8;
  localparam int OS = 2;
  localparam int WW = 8;
  localparam int BL = 4;
  localparam int BW = 32;
  localparam int NW = IS*OS/BL;
  localparam int NB = IS*OS + OS*(BW/WW);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        loaded;
  logic        load_err;
  logic        w_read_en = 1'b0;
  logic [3:0]  w_read_addr = 4'h0;
  logic [31:0] w_read_data;
  logic        b_read_en = 1'b0;
  logic [0:0]  b_read_addr = 1'b0;
  logic [31:0] b_read_data;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  stream [NB];
  logic [31:0] m_word [NW];
  logic [31:0] m_bias [OS];
  logic [31:0] rw, rb;

  fc_param_store #(
    .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .WEIGHTS_WIDTH(WW), .BURST_LEN(BL), .BIAS_WIDTH(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .loaded(loaded), .load_err(load_err),
    .w_read_en(w_read_en), .w_read_addr(w_read_addr), .w_read_data(w_read_data),
    .b_read_en(b_read_en), .b_read_addr(b_read_addr), .b_read_data(b_read_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Words/biases whose bytes all arrived among the first n good beats are stored
  function automatic void model_commit(input int n);
    for (int k = 0; k < NW; k++)
      if (BL*k + BL <= n)
        m_word[k] = {stream[4*k], stream[4*k+1], stream[4*k+2], stream[4*k+3]};
    for (int j = 0; j < OS; j++) begin
      int base = IS*OS + 4*j;
      if (base + 4 <= n)
        m_bias[j] = {stream[base], stream[base+1], stream[base+2], stream[base+3]};
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = s_ready;
      tick();
      n++;
    end
    if (!acc) check_val("beat_timeout", 64'(acc), 64'h1);
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = 8'($urandom);
  endtask

  task automatic gaps(input int pct);
    int g;
    g = 0;
    while (($urandom_range(0, 99) < pct) && g < 4) begin
      s_data = 8'($urandom);
      tick();
      g++;
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    check_val("start_err_clr", 64'(load_err), 64'h0);
    check_val("start_loaded_clr", 64'(loaded), 64'h0);
    check_val("start_s_ready", 64'(s_ready), 64'h1);
    tick();
  endtask

  // mode 0: proper s_last; 1: s_last early at beat pos; 2: no s_last at all
  task automatic do_load(input bit start, input int pct, input int mode, input int pos);
    logic last;
    int   n_good;
    if (start) pulse_start();
    for (int i = 0; i < NB; i++) begin
      gaps(pct);
      last = (mode == 0) ? (i == NB-1) : ((mode == 1) ? (i == pos) : 1'b0);
      beat(stream[i], last);
      if (mode == 1 && i == pos) break;
    end
    n_good = (mode == 0) ? NB : ((mode == 1) ? pos : NB-1);
    model_commit(n_good);
    @(negedge clk);
    check_val("loaded", 64'(loaded), 64'(mode == 0));
    check_val("load_err", 64'(load_err), 64'(mode != 0));
    check_val("s_ready_after", 64'(s_ready), 64'h0);
    tick();
  endtask

  task automatic rd(input logic [3:0] wa, input logic [0:0] ba);
    w_read_en = 1'b1;
    b_read_en = 1'b1;
    w_read_addr = wa;
    b_read_addr = ba;
    tick();
    w_read_en = 1'b0;
    b_read_en = 1'b0;
    w_read_addr = 4'($urandom);
    b_read_addr = 1'($urandom);
    @(negedge clk);
    rw = w_read_data;
    rb = b_read_data;
    tick();
  endtask

  task automatic check_all();
    logic [3:0] wa;
    for (int k = 0; k < NW; k++) begin
      wa = 4'(BL*k + $urandom_range(0, BL-1));
      rd(wa, 1'(k % OS));
      check_val($sformatf("rd_w%0d", k), 64'(rw), 64'(m_word[k]));
      check_val($sformatf("rd_b%0d", k % OS), 64'(rb), 64'(m_bias[k % OS]));
    end
  endtask

  task automatic set_det_stream();
    for (int i = 0; i < IS*OS; i++) stream[i] = 8'(i + 1);
    stream[16] = 8'h00; stream[17] = 8'h00; stream[18] = 8'h00; stream[19] = 8'h64;
    stream[20] = 8'hFF; stream[21] = 8'hFF; stream[22] = 8'hFF; stream[23] = 8'h9C;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m;
    // Reset state
    tick(); tick(); tick();
    @(negedge clk);
    check_val("rst_loaded", 64'(loaded), 64'h0);
    check_val("rst_load_err", 64'(load_err), 64'h0);
    check_val("rst_s_ready", 64'(s_ready), 64'h0);
    check_val("rst_w_data", 64'(w_read_data), 64'h0);
    check_val("rst_b_data", 64'(b_read_data), 64'h0);
    rst_n = 1'b1;
    tick();

    // Known-pattern load, back-to-back beats
    set_det_stream();
    do_load(1'b1, 0, 0, 0);
    rd(4'd0, 1'b1);
    check_val("det_w0", 64'(rw), 64'h01020304);
    check_val("det_b1", 64'(rb), 64'hFFFFFF9C);
    rd(4'd12, 1'b0);
    check_val("det_w12", 64'(rw), 64'h0D0E0F10);
    check_val("det_b0", 64'(rb), 64'h00000064);
    check_all();

    // Same load with valid gaps
    do_load(1'b1, 40, 0, 0);
    rd(4'd5, 1'b1);
    check_val("gap_w5", 64'(rw), 64'h05060708);
    check_all();

    // Hold when read enable is low
    rd(4'd4, 1'b0);
    check_val("hold_first", 64'(rw), 64'h05060708);
    for (int c = 0; c < 3; c++) begin
      w_read_addr = 4'($urandom);
      @(negedge clk);
      check_val("hold", 64'(w_read_data), 64'h05060708);
      tick();
    end

    // s_last on beat 10 aborts the load
    do_load(1'b1, 0, 1, 10);
    check_all();
    pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;

    // Reset mid-load after 6 beats
    for (int i = 0; i < 6; i++) beat(stream[i], 1'b0);
    model_commit(6);
    rst_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    check_val("mid_rst_loaded", 64'(loaded), 64'h0);
    check_val("mid_rst_w_data", 64'(w_read_data), 64'h0);
    check_val("mid_rst_b_data", 64'(b_read_data), 64'h0);
    check_val("mid_rst_s_ready", 64'(s_ready), 64'h0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NB; i++) stream[i] = 8'($urandom);
    do_load(1'b1, 20, 0, 0);
    check_all();

    // load_start collides with a valid beat in LOAD_W: beat refused, counters restart
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) beat(8'($urandom), 1'b0);
    load_start = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hAA;
    @(negedge clk);
    check_val("ls_collide_s_ready", 64'(s_ready), 64'h0);
    tick();
    load_start = 1'b0;
    s_valid = 1'b0;
    for (int i = 0; i < NB; i++) stream[i] = 8'($urandom);
    do_load(1'b0, 0, 0, 0);
    check_all();

    // Randomized loads: good, early s_last, missing s_last
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NB; i++) stream[i] = 8'($urandom);
      m = $urandom_range(0, 3);
      m = (m < 2) ? 0 : m - 1;
      do_load(1'b1, $urandom_range(0, 50), m, $urandom_range(0, NB-2));
      check_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
